// File: rtl/jk_reg_arbiter.sv
// jk_reg_arbiter: round-robin arbitrated LOAD/SET/CLEAR/TOGGLE access to a shared JK-flop register.
// Define JK_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module jk_reg_arbiter #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8,
   localparam int IW = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req,
   input  logic [2*N_REQ-1:0]     op,
   input  logic [WIDTH*N_REQ-1:0] data,
   output logic [N_REQ-1:0]       gnt,
   output logic [IW-1:0]          owner,
   output logic                   busy,
   output logic                   done,
   output logic [WIDTH-1:0]       q
);
   typedef enum logic {IDLE, APPLY} state_t;
   state_t           state_q, state_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [IW-1:0]    owner_q, owner_d, ptr_q, ptr_d, win, idx;
   logic             busy_q, busy_d, done_q, done_d, found;
   logic [WIDTH-1:0] q_q, q_d, data_c_q, data_c_d, j, k;
   logic [1:0]       op_c_q, op_c_d;
   always_comb begin
      found = 1'b0;
      win = '0;
      idx = '0;
`ifdef JK_ARB_FIXED_PRIO_EN
      for (int i = N_REQ - 1; i >= 0; i--) begin
         idx = IW'(i);
         if (req[idx]) begin
            found = 1'b1;
            win = idx;
         end
      end
`else
      for (int i = 0; i < N_REQ; i++) begin
         idx = IW'((int'(ptr_q) + i) % N_REQ);
         if (!found && req[idx]) begin
            found = 1'b1;
            win = idx;
         end
      end
`endif
   end
   // JK inputs per bit from the captured command; q+ = J&~q | ~K&q
   always_comb begin
      j = (op_c_q == 2'b10) ? '0 : data_c_q;
      k = (op_c_q == 2'b00) ? ~data_c_q : (op_c_q == 2'b01) ? '0 : data_c_q;
   end
   always_comb begin
      state_d  = state_q;
      gnt_d    = '0;
      owner_d  = owner_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      ptr_d    = ptr_q;
      q_d      = q_q;
      op_c_d   = op_c_q;
      data_c_d = data_c_q;
      if (state_q == APPLY) begin
         q_d     = (j & ~q_q) | (~k & q_q);
         busy_d  = 1'b0;
         done_d  = 1'b1;
         ptr_d   = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
         state_d = IDLE;
      end else if (found) begin
         gnt_d    = N_REQ'(1) << win;
         owner_d  = win;
         busy_d   = 1'b1;
         op_c_d   = op[{win, 1'b0} +: 2];
         data_c_d = data[WIDTH*win +: WIDTH];
         state_d  = APPLY;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         gnt_q    <= '0;
         owner_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ptr_q    <= '0;
         q_q      <= '0;
         op_c_q   <= '0;
         data_c_q <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         owner_q  <= owner_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         ptr_q    <= ptr_d;
         q_q      <= q_d;
         op_c_q   <= op_c_d;
         data_c_q <= data_c_d;
      end
   end
   assign gnt   = gnt_q;
   assign owner = owner_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign q     = q_q;
endmodule

// File: tb/tb_jk_reg_arbiter.sv
// tb_jk_reg_arbiter: scoreboard-driven bench for jk_reg_arbiter (N_REQ=4, WIDTH=8).
module tb_jk_reg_arbiter;
   localparam int N = 4;
   localparam int W = 8;
   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic [N-1:0]   req = '0;
   logic [2*N-1:0] op = '0;
   logic [W*N-1:0] data = '0;
   logic [N-1:0]   gnt;
   logic [1:0]     owner;
   logic           busy, done;
   logic [W-1:0]   q;
   int n_cmp = 0;
   int n_bad = 0;
   logic [N-1:0] exp_gnt_q[$];
   logic [W-1:0] exp_q_q[$];

   jk_reg_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .op(op), .data(data),
      .gnt(gnt), .owner(owner), .busy(busy), .done(done), .q(q)
   );

   always #5 clk = ~clk;

   task set_cmd(input int i, input logic [1:0] o, input logic [W-1:0] d);
      op[2*i +: 2] = o;
      data[W*i +: W] = d;
   endtask

   task do_reset;
      rst_n = 1'b0;
      req = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // one request from requester i; expectations are queued before driving
   task run_cmd(input int i, input logic [1:0] o, input logic [W-1:0] d, input logic [W-1:0] eq);
      logic [N-1:0] eg;
      logic [W-1:0] ev;
      int t;
      exp_gnt_q.push_back(N'(1) << i);
      exp_q_q.push_back(eq);
      set_cmd(i, o, d);
      req[i] = 1'b1;
      t = 0;
      @(negedge clk);
      while (gnt == '0 && t < 10) begin
         @(negedge clk);
         t++;
      end
      eg = exp_gnt_q.pop_front();
      n_cmp++;
      if (gnt !== eg) begin n_bad++; $display("FAIL cmd%0d gnt: got %b want %b", i, gnt, eg); end
      n_cmp++;
      if (owner !== 2'(i)) begin n_bad++; $display("FAIL cmd%0d owner: got %0d want %0d", i, owner, i); end
      n_cmp++;
      if (busy !== 1'b1) begin n_bad++; $display("FAIL cmd%0d busy: got %b want 1", i, busy); end
      req[i] = 1'b0;
      @(negedge clk);
      ev = exp_q_q.pop_front();
      n_cmp++;
      if (q !== ev) begin n_bad++; $display("FAIL cmd%0d q: got %h want %h", i, q, ev); end
      n_cmp++;
      if (done !== 1'b1 || gnt !== '0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL cmd%0d done/gnt/busy: got %b/%b/%b want 1/0000/0", i, done, gnt, busy);
      end
   endtask

   task test_reset;
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({q, gnt, busy, done, owner} !== '0) begin
         n_bad++;
         $display("FAIL reset: got q=%h gnt=%b busy=%b done=%b owner=%0d want all 0", q, gnt, busy, done, owner);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task test_single;
      run_cmd(1, 2'b00, 8'hA5, 8'hA5);
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || q !== 8'hA5) begin
         n_bad++;
         $display("FAIL single_after: got done=%b q=%h want done=0 q=a5", done, q);
      end
   endtask

   task test_cmd_mix;
      run_cmd(0, 2'b11, 8'h0F, 8'hAA);
      run_cmd(2, 2'b01, 8'h01, 8'hAB);
      run_cmd(3, 2'b10, 8'h80, 8'h2B);
      run_cmd(1, 2'b11, 8'h00, 8'h2B);
      run_cmd(2, 2'b01, 8'h00, 8'h2B);
   endtask

   task test_contention;
      logic [N-1:0] eg;
      logic [W-1:0] ev;
      int cyc, last;
      do_reset();
      for (int i = 0; i < N; i++) set_cmd(i, 2'b00, W'(i));
      for (int i = 0; i < 5; i++) begin
`ifdef JK_ARB_FIXED_PRIO_EN
         exp_gnt_q.push_back(4'b0001);
         exp_q_q.push_back(8'h00);
`else
         exp_gnt_q.push_back(N'(1) << (i % N));
         exp_q_q.push_back(W'(i % N));
`endif
      end
      req = '1;
      cyc = 0;
      last = -1;
      while ((exp_gnt_q.size() > 0 || exp_q_q.size() > 0) && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (gnt !== '0 && exp_gnt_q.size() > 0) begin
            eg = exp_gnt_q.pop_front();
            n_cmp++;
            if (gnt !== eg) begin n_bad++; $display("FAIL contention gnt: got %b want %b", gnt, eg); end
            if (last >= 0) begin
               n_cmp++;
               if (cyc - last != 2) begin n_bad++; $display("FAIL contention gap: got %0d want 2", cyc - last); end
            end
            last = cyc;
         end
         if (done === 1'b1 && exp_q_q.size() > 0) begin
            ev = exp_q_q.pop_front();
            n_cmp++;
            if (q !== ev) begin n_bad++; $display("FAIL contention q: got %h want %h", q, ev); end
         end
      end
      req = '0;
      n_cmp++;
      if (exp_gnt_q.size() != 0 || exp_q_q.size() != 0) begin
         n_bad++;
         $display("FAIL contention timeout: got %0d/%0d left want 0/0", exp_gnt_q.size(), exp_q_q.size());
         exp_gnt_q.delete();
         exp_q_q.delete();
      end
      @(negedge clk);
   endtask

   task test_reset_apply;
      int t;
      do_reset();
      run_cmd(1, 2'b00, 8'hFF, 8'hFF);
      set_cmd(2, 2'b00, 8'h5A);
      req[2] = 1'b1;
      t = 0;
      @(negedge clk);
      while (gnt == '0 && t < 10) begin
         @(negedge clk);
         t++;
      end
      n_cmp++;
      if (gnt !== 4'b0100) begin n_bad++; $display("FAIL rst_apply gnt: got %b want 0100", gnt); end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (q !== 8'h00 || gnt !== '0 || busy !== 1'b0 || done !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_apply async: got q=%h gnt=%b busy=%b done=%b want 00/0000/0/0", q, gnt, busy, done);
      end
      for (int i = 0; i < N; i++) set_cmd(i, 2'b00, W'(i + 8'h10));
      req = '1;
      repeat (2) begin
         @(negedge clk);
         n_cmp++;
         if (done !== 1'b0 || q !== 8'h00) begin
            n_bad++;
            $display("FAIL rst_apply hold: got done=%b q=%h want 0/00", done, q);
         end
      end
      rst_n = 1'b1;
      t = 0;
      @(negedge clk);
      while (gnt == '0 && t < 10) begin
         @(negedge clk);
         t++;
      end
      n_cmp++;
      if (gnt !== 4'b0001) begin n_bad++; $display("FAIL rst_apply first: got %b want 0001", gnt); end
      req = '0;
      @(negedge clk);
      n_cmp++;
      if (q !== 8'h10 || done !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_apply load: got q=%h done=%b want 10/1", q, done);
      end
      @(negedge clk);
   endtask

   task test_macro;
      logic [N-1:0] eg;
      logic [W-1:0] ev;
      int cyc;
      do_reset();
      set_cmd(1, 2'b00, 8'h11);
      set_cmd(3, 2'b00, 8'h33);
      for (int i = 0; i < 4; i++) begin
`ifdef JK_ARB_FIXED_PRIO_EN
         exp_gnt_q.push_back(4'b0010);
         exp_q_q.push_back(8'h11);
`else
         exp_gnt_q.push_back(i[0] ? 4'b1000 : 4'b0010);
         exp_q_q.push_back(i[0] ? 8'h33 : 8'h11);
`endif
      end
      req = 4'b1010;
      cyc = 0;
      while ((exp_gnt_q.size() > 0 || exp_q_q.size() > 0) && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (gnt !== '0 && exp_gnt_q.size() > 0) begin
            eg = exp_gnt_q.pop_front();
            n_cmp++;
            if (gnt !== eg) begin n_bad++; $display("FAIL macro gnt: got %b want %b", gnt, eg); end
         end
         if (done === 1'b1 && exp_q_q.size() > 0) begin
            ev = exp_q_q.pop_front();
            n_cmp++;
            if (q !== ev) begin n_bad++; $display("FAIL macro q: got %h want %h", q, ev); end
         end
      end
      req = '0;
      n_cmp++;
      if (exp_gnt_q.size() != 0 || exp_q_q.size() != 0) begin
         n_bad++;
         $display("FAIL macro timeout: got %0d/%0d left want 0/0", exp_gnt_q.size(), exp_q_q.size());
         exp_gnt_q.delete();
         exp_q_q.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single();
      test_cmd_mix();
      test_contention();
      test_reset_apply();
      test_macro();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/jk_reg_arbiter.md
Name: jk_reg_arbiter

Overview:
- Shared WIDTH-bit register built from JK flip-flops. The J/K input of each bit is computed from the command being executed.
- N_REQ requesters compete for write access using req/gnt. Round-robin arbitration picks one winner, then applies its command for one cycle: LOAD (D-style), SET, CLEAR or TOGGLE.
- Sits between independent control agents and a single shared status/control register.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, register width in bits

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  N_REQ  request per requester; held high until gnt seen
- op  input  2*N_REQ  command of requester i at bits [2i+1:2i]
- data  input  WIDTH*N_REQ  data/mask of requester i at bits [WIDTH*i+WIDTH-1:WIDTH*i]
- gnt  output  N_REQ  one-hot grant, one-cycle pulse
- owner  output  $clog2(N_REQ)  index of most recent winner
- busy  output  1  high while a command is being applied
- done  output  1  one-cycle pulse after the register updates
- q  output  WIDTH  register contents

Behaviour:
- Reset (asynchronous, while rst_n=0):
  - q=0, gnt=0, owner=0, busy=0, done=0.
  - Round-robin pointer=0, state=IDLE.
  - Any captured command is discarded.
- State machine, two states, IDLE and APPLY:
  - IDLE, no req bit high: remain IDLE; outputs hold their values, done=0.
  - IDLE, any req bit high at an edge: select winner w. Search starts at the pointer and wraps modulo N_REQ; first high req wins. At that edge: gnt=(1<<w), owner=w, busy=1, capture op/data of w into internal registers, state goes to APPLY.
  - APPLY: J/K are derived from the captured op/data. At the next edge: q updates, gnt=0, busy=0, done=1, pointer=(w+1) mod N_REQ, state goes to IDLE.
  - done stays high for exactly one cycle. That IDLE cycle can arbitrate, so back-to-back operations are possible.
- Latency: q reflects the command one edge after the grant edge. Maximum throughput is one command every 2 cycles.
- Requester rule:
  - op/data must be valid whenever req is high.
  - req must be low by the edge after gnt is seen; otherwise it is treated as a new request.
  - req inputs are ignored during APPLY.
- Per-bit JK function, mask m = captured data bit:
  - op 00 LOAD: J=m, K=~m, so q=data.
  - op 01 SET: J=m, K=0.
  - op 10 CLEAR: J=0, K=m.
  - op 11 TOGGLE: J=m, K=m.
  - JK next state: 00 hold, 10 set, 01 clear, 11 invert.
- Bits whose mask is 0 hold their value for SET, CLEAR and TOGGLE.
- Pointer wraps from N_REQ-1 to 0.
- Simultaneous requests: exactly one grant per arbitration. Losers stay pending with no state loss.
- Reset asserted during APPLY: q clears immediately, done does not pulse, the command is lost. After release, arbitration restarts from index 0.

Optional Feature:
- Macro JK_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. The lowest-index high req always wins, and the pointer is not used (may be removed).
- Undefined: round-robin as described above.
- All other timing is identical in both modes.

Test Plan (N_REQ=4, WIDTH=8):
- Reset: rst_n=0 mid-run -> q=0x00, gnt=0000, busy=0, done=0 immediately, without waiting for a clock edge.
- Single request: req[1]=1, op1=00, data1=0xA5 -> gnt=0010 for one cycle, owner=1. q=0xA5 and done=1 at the following edge.
- Command mix, starting from q=0xA5:
  - req0 TOGGLE 0x0F -> q=0xAA
  - req2 SET 0x01 -> q=0xAB
  - req3 CLEAR 0x80 -> q=0x2B
  - Unmasked bits are unchanged.
- Contention: all four req held continuously, each LOADing its own index. Expected:
  - grant order 0,1,2,3,0 starting from reset
  - gnt pulses every 2nd cycle
  - q sequence 0x00,0x01,0x02,0x03,0x00
- Reset during APPLY: assert rst_n=0 in the cycle gnt=0100 is high -> q=0, no done pulse. After release with all req high, the first grant is 0001.
- Macro test: req1 and req3 held high.
  - JK_ARB_FIXED_PRIO_EN defined -> gnt=0010 on every arbitration.
  - Undefined -> gnt alternates 0010, 1000.
